// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
//
// Converts the 2N-bit unsigned adder sum into DIGITS packed BCD digits.
// It processes one input bit per clock and uses a start/ready/done handshake.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled only while ready=1
//   bin       2N-bit unsigned input, captured on the accepted start edge
//   ready     high while idle and able to accept start
//   done      one-cycle pulse, bcd/overflow valid from this cycle onward
//   bcd       packed BCD result, digit 0 (units) in bits [3:0]
//   overflow  input value exceeded 10^DIGITS-1 (bcd then holds the low digits)

module bin2bcd_seq #(
  parameter int N      = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*N-1:0]        bin,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 2 * N;
  localparam int SW = 4 * DIGITS;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [BW-1:0]   shreg_q;
  logic [SW-1:0]   scratch_q;
  logic            ovf_s_q;
  logic [CW-1:0]   cnt_q;

  logic            load_en;
  logic            step_en;
  logic            last_step;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   step_scratch;
  logic [BW-1:0]   step_shreg;
  logic            step_carry;

  // Add-3 correction on every digit >= 5 before the shift, so that a digit
  // crossing 10 carries into the next digit after the doubling.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit means the value has reached 10^DIGITS.
  // Dropping it leaves the scratch holding the value modulo 10^DIGITS.
  always_comb begin
    step_scratch = {adj[SW-2:0], shreg_q[BW-1]};
    step_shreg   = {shreg_q[BW-2:0], 1'b0};
    step_carry   = adj[SW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    load_en   = 1'b0;
    step_en   = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load_en = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step_en = 1'b1;
        if (cnt_q == '0) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The published result is taken from the final step directly. This lets
  // bcd/overflow change only on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      ovf_s_q   <= 1'b0;
      cnt_q     <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else if (load_en) begin
      shreg_q   <= bin;
      scratch_q <= '0;
      ovf_s_q   <= 1'b0;
      cnt_q     <= CNT_LOAD;
    end else if (step_en) begin
      shreg_q   <= step_shreg;
      scratch_q <= step_scratch;
      ovf_s_q   <= ovf_s_q | step_carry;
      if (last_step) begin
        bcd      <= step_scratch;
        overflow <= ovf_s_q | step_carry;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule
